player_motion_ctrl: RTL and testbench

Parametrised per-player motion controller for the volley game: clamps the mouse X position to the player's half-court and runs a fixed-point gravity jump on Y. It generates its own physics tick from the pixel clock with an internal enable counter, so it needs no divided clock. It sits between the mouse interface and the player sprite and ball-collision logic. One instance is used per player, with different X limits.

---
 rtl/player_motion_ctrl.sv | 169 ++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl
// Per-player motion controller: clamps mouse X to the player's half-court and
// runs a fixed-point gravity jump on Y, updated once per internal physics tick.
//
// Ports
//   clk               pixel clock (only clock)
//   rst               asynchronous active-low reset
//   xpos              raw mouse X
//   click_mouse       mouse button level
//   xpos_limit        clamped X, updated on tick
//   ypos_limit        integer part of fixed-point Y, updated on tick
//   click_mouse_limit click level sampled at the last tick
//   airborne          high while rising or falling
//   tick              one-clk pulse; state registers update on the edge ending it
module player_motion_ctrl #(
    parameter int unsigned X_MIN     = 0,
    parameter int unsigned X_MAX     = 500,
    parameter int unsigned GROUND_Y  = 679,
    parameter int unsigned CEIL_Y    = 0,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned JUMP_V0   = 4096,
    parameter int unsigned GRAVITY   = 128,
    parameter int unsigned V_MAX     = 4096,
    parameter int unsigned TICK_DIV  = 650000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic        click_mouse,
    output logic [11:0] xpos_limit,
    output logic [11:0] ypos_limit,
    output logic        click_mouse_limit,
    output logic        airborne,
    output logic        tick
);

    localparam int unsigned W  = 12 + FRAC_BITS;
    localparam int unsigned WC = 13 + FRAC_BITS;
    localparam int unsigned CW = $clog2(TICK_DIV);

    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(TICK_DIV - 2);
    localparam logic [WC-1:0] GROUND_FP = WC'(GROUND_Y) << FRAC_BITS;
    localparam logic [WC-1:0] CEIL_FP   = WC'(CEIL_Y) << FRAC_BITS;
    localparam logic [WC-1:0] JUMP_FP   = WC'(JUMP_V0);
    localparam logic [WC-1:0] GRAV_FP   = WC'(GRAVITY);
    localparam logic [WC-1:0] VMAX_FP   = WC'(V_MAX);
    localparam logic [11:0]   X_LO      = 12'(X_MIN);
    localparam logic [11:0]   X_HI      = 12'(X_MAX);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        LAND   = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [W-1:0]  y_fp, y_d;
    logic [W-1:0]  v, v_d;
    logic          click_prev;
    logic [CW-1:0] cnt;

    logic          jump_edge_c;
    logic [11:0]   x_clamp_c;
    logic [WC-1:0] y_ext, v_ext, y_up, y_dn, v_up, ceil_lim;

    // Physics tick generator; tick is registered so it is high while cnt is at its last value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            tick <= (cnt == CNT_PRE);
        end
    end

    assign jump_edge_c = click_mouse & ~click_prev;

    // X clamp; equality folded into the limit branches so X_MIN=0 gives no constant compare
    always_comb begin
        x_clamp_c = xpos;
        if (xpos <= X_LO) begin
            x_clamp_c = X_LO;
        end else if (xpos >= X_HI) begin
            x_clamp_c = X_HI;
        end
    end

    // Jump FSM next state; all arithmetic one bit wider than the state so nothing wraps
    always_comb begin
        state_d  = state;
        y_d      = y_fp;
        v_d      = v;
        y_ext    = {1'b0, y_fp};
        v_ext    = {1'b0, v};
        y_up     = y_ext + v_ext;
        y_dn     = y_ext - v_ext;
        v_up     = v_ext + GRAV_FP;
        ceil_lim = v_ext + CEIL_FP;
        case (state)
            GROUND: begin
                y_d = W'(GROUND_FP);
                v_d = '0;
                if (jump_edge_c) begin
                    state_d = RISE;
                    v_d     = W'(JUMP_FP);
                end
            end
            RISE: begin
                if (v_ext > GRAV_FP) begin
                    // y - v < ceil, tested as y < v + ceil to avoid underflow
                    if (y_ext < ceil_lim) begin
                        y_d     = W'(CEIL_FP);
                        v_d     = '0;
                        state_d = FALL;
                    end else begin
                        y_d = W'(y_dn);
                        v_d = W'(v_ext - GRAV_FP);
                    end
                end else begin
                    v_d     = '0;
                    state_d = FALL;
                end
            end
            FALL: begin
                if (y_up >= GROUND_FP) begin
                    y_d     = W'(GROUND_FP);
                    v_d     = '0;
                    state_d = LAND;
                end else begin
                    y_d = W'(y_up);
                    v_d = (v_up > VMAX_FP) ? W'(VMAX_FP) : W'(v_up);
                end
            end
            LAND: begin
                state_d = GROUND;
            end
            default: begin
                state_d = GROUND;
            end
        endcase
    end

    // State and output registers, advanced only on physics ticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= GROUND;
            y_fp              <= W'(GROUND_FP);
            v                 <= '0;
            click_prev        <= 1'b0;
            xpos_limit        <= X_LO;
            ypos_limit        <= 12'(GROUND_Y);
            click_mouse_limit <= 1'b0;
            airborne          <= 1'b0;
        end else if (tick) begin
            state             <= state_d;
            y_fp              <= y_d;
            v                 <= v_d;
            click_prev        <= click_mouse;
            click_mouse_limit <= click_mouse;
            xpos_limit        <= x_clamp_c;
            ypos_limit        <= y_d[W-1:FRAC_BITS];
            airborne          <= (state_d == RISE) || (state_d == FALL);
        end
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Testbench for player_motion_ctrl: three instances (default, low ceiling,
// low fall-speed cap) share stimulus and are checked against a behavioural
// model after every physics tick, plus targeted jump/reset sequences.
module tb_player_motion_ctrl;

    localparam int TD    = 4;
    localparam int GND   = 679;
    localparam int GFP   = 679 * 256;
    localparam int V0    = 4096;
    localparam int GRAV  = 128;

    localparam int M_GROUND = 0;
    localparam int M_UP     = 1;
    localparam int M_DOWN   = 2;
    localparam int M_LANDED = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] xpos = '0;
    logic        click = 1'b0;

    logic [11:0] xl_a, yl_a, xl_c, yl_c, xl_v, yl_v;
    logic        cl_a, ab_a, tk_a, cl_c, ab_c, tk_c, cl_v, ab_v, tk_v;

    logic [11:0] xl [3];
    logic [11:0] yl [3];
    logic        cl [3];
    logic        ab [3];

    assign xl[0] = xl_a; assign xl[1] = xl_c; assign xl[2] = xl_v;
    assign yl[0] = yl_a; assign yl[1] = yl_c; assign yl[2] = yl_v;
    assign cl[0] = cl_a; assign cl[1] = cl_c; assign cl[2] = cl_v;
    assign ab[0] = ab_a; assign ab[1] = ab_c; assign ab[2] = ab_v;

    always #5 clk = ~clk;

    player_motion_ctrl #(.TICK_DIV(TD)) dut_a (
        .clk(clk), .rst(rst), .xpos(xpos), .click_mouse(click),
        .xpos_limit(xl_a), .ypos_limit(yl_a), .click_mouse_limit(cl_a),
        .airborne(ab_a), .tick(tk_a)
    );

    player_motion_ctrl #(.TICK_DIV(TD), .CEIL_Y(450)) dut_c (
        .clk(clk), .rst(rst), .xpos(xpos), .click_mouse(click),
        .xpos_limit(xl_c), .ypos_limit(yl_c), .click_mouse_limit(cl_c),
        .airborne(ab_c), .tick(tk_c)
    );

    player_motion_ctrl #(.TICK_DIV(TD), .V_MAX(1024)) dut_v (
        .clk(clk), .rst(rst), .xpos(xpos), .click_mouse(click),
        .xpos_limit(xl_v), .ypos_limit(yl_v), .click_mouse_limit(cl_v),
        .airborne(ab_v), .tick(tk_v)
    );

    // Behavioural player: fixed-point y, signed velocity (negative = upward)
    typedef struct {
        int mode;
        int y;
        int vel;
        bit cp;
        bit cl;
        int xl;
    } mstate_t;

    mstate_t m [3];
    int ceil_p [3] = '{0, 450, 0};
    int vmax_p [3] = '{4096, 4096, 1024};

    typedef struct {
        int x;
        int exp_x;
    } xvec_t;
    xvec_t xv [8];

    int n_checks = 0;
    int n_fail   = 0;
    int wt;

    function automatic mstate_t m_reset();
        mstate_t s;
        s.mode = M_GROUND; s.y = GFP; s.vel = 0; s.cp = 1'b0; s.cl = 1'b0; s.xl = 0;
        return s;
    endfunction

    function automatic mstate_t m_next(mstate_t s, int ceil_y, int vmax, int x, bit c);
        mstate_t n = s;
        int ny;
        bit jmp = c && !s.cp;
        n.xl = (x < 0) ? 0 : ((x > 500) ? 500 : x);
        n.cl = c;
        n.cp = c;
        case (s.mode)
            M_GROUND: begin
                n.y = GFP; n.vel = 0;
                if (jmp) begin n.mode = M_UP; n.vel = -V0; end
            end
            M_UP: begin
                if (-s.vel > GRAV) begin
                    ny = s.y + s.vel;
                    if (ny < ceil_y * 256) begin
                        n.y = ceil_y * 256; n.vel = 0; n.mode = M_DOWN;
                    end else begin
                        n.y = ny; n.vel = s.vel + GRAV;
                    end
                end else begin
                    n.vel = 0; n.mode = M_DOWN;
                end
            end
            M_DOWN: begin
                ny = s.y + s.vel;
                if (ny >= GFP) begin
                    n.y = GFP; n.vel = 0; n.mode = M_LANDED;
                end else begin
                    n.y = ny;
                    n.vel = (s.vel + GRAV > vmax) ? vmax : s.vel + GRAV;
                end
            end
            default: n.mode = M_GROUND;
        endcase
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Entered at a negedge: drive inputs, wait for tick, let the update edge pass, check all instances
    task automatic step_tick(input int x, input bit c, output int waited);
        waited = 0;
        xpos  = 12'(x);
        click = c;
        while (tk_a !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (tk_a !== 1'b1) check("tick_timeout", 32'(tk_a), 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            m[i] = m_next(m[i], ceil_p[i], vmax_p[i], x, c);
            check($sformatf("xpos_limit[%0d]", i), 32'(xl[i]), 32'(m[i].xl));
            check($sformatf("ypos_limit[%0d]", i), 32'(yl[i]), 32'(m[i].y / 256));
            check($sformatf("click_limit[%0d]", i), 32'(cl[i]), 32'(m[i].cl));
            check($sformatf("airborne[%0d]", i), 32'(ab[i]),
                  32'(m[i].mode == M_UP || m[i].mode == M_DOWN));
        end
        check("tick_one_clk", 32'(tk_a), 0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int rise_moves, min_a, min_c, hold450, max_step_v, prev_a, prev_v, jumps, cyc;
        bit prev_ab, cr;

        xv[0] = '{700, 500};
        xv[1] = '{250, 250};
        xv[2] = '{0, 0};
        xv[3] = '{500, 500};
        xv[4] = '{501, 500};
        xv[5] = '{499, 499};
        xv[6] = '{4095, 500};
        xv[7] = '{1, 1};

        for (int i = 0; i < 3; i++) m[i] = m_reset();

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_xpos", 32'(xl[i]), 0);
            check("reset_ypos", 32'(yl[i]), GND);
            check("reset_click", 32'(cl[i]), 0);
            check("reset_airborne", 32'(ab[i]), 0);
        end
        check("reset_tick", 32'(tk_a), 0);
        rst = 1'b1;

        // X clamp table and tick period
        for (int i = 0; i < 8; i++) begin
            step_tick(xv[i].x, 1'b0, wt);
            check($sformatf("xclamp_%0d", xv[i].x), 32'(xl_a), 32'(xv[i].exp_x));
            if (i > 0) check("tick_period", 32'(wt + 1), TD);
        end

        // Full jump on all three instances, with a press during the fall
        step_tick(250, 1'b1, wt);
        check("launch_airborne", 32'(ab_a), 1);
        check("launch_y_unchanged", 32'(yl_a), GND);
        step_tick(250, 1'b0, wt);
        check("first_rise_step", 32'(yl_a), 663);
        rise_moves = 1; min_a = yl_a; min_c = yl_c; hold450 = 0; max_step_v = 0;
        prev_a = yl_a; prev_v = yl_v;
        for (int t = 0; t < 300 && (ab_a || ab_c || ab_v); t++) begin
            step_tick(100 + t, (t == 40), wt);
            if (int'(yl_a) < prev_a) rise_moves++;
            if (int'(yl_a) < min_a) min_a = yl_a;
            if (int'(yl_c) < min_c) min_c = yl_c;
            if (yl_c == 12'd450) hold450++;
            if (int'(yl_v) - prev_v > max_step_v) max_step_v = int'(yl_v) - prev_v;
            prev_a = yl_a; prev_v = yl_v;
        end
        check("rise_moving_ticks", 32'(rise_moves), 31);
        check("apex_ypos", 32'(min_a), 415);
        check("ceil_min_ypos", 32'(min_c), 450);
        check("ceil_hold_ticks", 32'(hold450), 3);
        check("vmax_fall_step", 32'(max_step_v), 4);
        check("landed_a", 32'(yl_a), GND);
        check("landed_v", 32'(yl_v), GND);
        check("landed_airborne_v", 32'(ab_v), 0);
        repeat (2) step_tick(300, 1'b0, wt);

        // Press in the landing tick is dropped, holding it afterwards does not jump
        step_tick(300, 1'b1, wt);
        for (int t = 0; t < 200 && ab_a; t++) step_tick(300, 1'b0, wt);
        step_tick(300, 1'b1, wt);
        check("land_press_ignored", 32'(ab_a), 0);
        step_tick(300, 1'b1, wt);
        check("held_after_land", 32'(ab_a), 0);
        repeat (150) step_tick(320, 1'b0, wt);

        // Held button gives exactly one jump; release and re-press gives another
        jumps = 0; prev_ab = ab_a;
        for (int t = 0; t < 200; t++) begin
            step_tick(50, 1'b1, wt);
            if (ab_a && !prev_ab) jumps++;
            prev_ab = ab_a;
        end
        check("held_single_jump", 32'(jumps), 1);
        check("held_grounded", 32'(ab_a), 0);
        step_tick(50, 1'b0, wt);
        step_tick(50, 1'b1, wt);
        check("second_jump", 32'(ab_a), 1);
        repeat (150) step_tick(60, 1'b0, wt);

        // Asynchronous reset in mid-rise
        step_tick(200, 1'b1, wt);
        repeat (5) step_tick(200, 1'b0, wt);
        check("mid_rise_ypos", 32'(yl_a), 604);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ypos", 32'(yl_a), GND);
        check("async_rst_airborne", 32'(ab_a), 0);
        check("async_rst_tick", 32'(tk_a), 0);
        for (int i = 0; i < 3; i++) m[i] = m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        while (tk_a !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("tick_after_reset", 32'(cyc), TD - 1);
        @(negedge clk);
        step_tick(200, 1'b0, wt);
        check("post_reset_ground", 32'(yl_a), GND);

        // Random stimulus against the model
        cr = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 5) == 0) cr = ~cr;
            step_tick(int'($urandom_range(0, 4095)), cr, wt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
